// File: rtl/dmem_responder.sv
// Data-port memory responder: req/gnt/rvalid slave with byte-enable SRAM model,
// programmable grant stall, fixed-latency in-order responses and integrity checking.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned GNT_STALL   = 0,
   parameter int unsigned RESP_LAT    = 1,
   parameter bit          INTG_CHECK  = 1'b1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   input  logic [6:0]  data_wdata_intg_i,
   output logic [31:0] data_rdata_o,
   output logic [6:0]  data_rdata_intg_o,
   output logic        data_err_o
);

   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4);

   function automatic logic [6:0] f_intg(input logic [31:0] d);
      logic [6:0] r;
      r = '0;
      for (int i = 0; i < 7; i++) begin
         for (int j = i; j < 32; j += 7) begin
            r[3'(i)] = r[3'(i)] ^ d[5'(j)];
         end
      end
      return r;
   endfunction

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [3:0]  r_stall_cnt;
   logic        r_pv [RESP_LAT];
   logic [31:0] r_pd [RESP_LAT];
   logic        r_pe [RESP_LAT];

   logic          w_stall_done;
   logic          w_gnt;
   logic          w_in_range;
   logic          w_misalign;
   logic          w_intg_bad;
   logic          w_err;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_rd_word;
   logic [31:0]   w_ins_data;

   assign w_stall_done = (r_stall_cnt == 4'(GNT_STALL));
   assign w_gnt        = RST_N & data_req_i & w_stall_done;

   assign w_in_range = ({1'b0, data_addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, data_addr_i} < END_ADDR);
   assign w_misalign = |data_addr_i[1:0];
   assign w_intg_bad = INTG_CHECK && data_we_i && (data_wdata_intg_i != f_intg(data_wdata_i));
   assign w_err      = !w_in_range || w_misalign || w_intg_bad;

   // Index is only meaningful after the range check; out-of-range accesses alias but are errored.
   assign w_idx      = AW'((data_addr_i - BASE_ADDR) >> 2);
   assign w_rd_word  = r_mem[w_idx];
   assign w_ins_data = (data_we_i || w_err) ? 32'h0 : w_rd_word;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_stall_cnt <= '0;
      end else if (!data_req_i || w_gnt) begin
         r_stall_cnt <= '0;
      end else if (!w_stall_done) begin
         r_stall_cnt <= r_stall_cnt + 4'd1;
      end
   end

   // Writes land at the end of the grant cycle, so a load granted next cycle reads new data.
   always_ff @(posedge CLK) begin
      if (w_gnt && data_we_i && !w_err) begin
         for (int k = 0; k < 4; k++) begin
            if (data_be_i[k]) r_mem[w_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < int'(RESP_LAT); i++) begin
            r_pv[i] <= 1'b0;
            r_pd[i] <= '0;
            r_pe[i] <= 1'b0;
         end
      end else begin
         r_pv[0] <= w_gnt;
         r_pd[0] <= w_gnt ? w_ins_data : 32'h0;
         r_pe[0] <= w_gnt & w_err;
         for (int i = 1; i < int'(RESP_LAT); i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pd[i] <= r_pd[i-1];
            r_pe[i] <= r_pe[i-1];
         end
      end
   end

   assign data_gnt_o        = w_gnt;
   assign data_rvalid_o     = r_pv[RESP_LAT-1];
   assign data_rdata_o      = r_pd[RESP_LAT-1];
   assign data_err_o        = r_pe[RESP_LAT-1];
   assign data_rdata_intg_o = f_intg(data_rdata_o);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one zero-stall/latency-1 instance and one
// stall-3/latency-4 instance, exercised in turn from a single initial block.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst0, rst1, req0, req1, we;
   logic [3:0]  be;
   logic [31:0] addr, wdata;
   logic [6:0]  wintg;

   logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
   logic [31:0] rdata0, rdata1;
   logic [6:0]  rintg0, rintg1;

   int checks   = 0;
   int failures = 0;

   logic [31:0] words [3];

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .GNT_STALL(0), .RESP_LAT(1), .INTG_CHECK(1'b1)
   ) u0 (
      .CLK(clk), .RST_N(rst0), .data_req_i(req0), .data_gnt_o(gnt0), .data_rvalid_o(rvalid0),
      .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
      .data_wdata_intg_i(wintg), .data_rdata_o(rdata0), .data_rdata_intg_o(rintg0),
      .data_err_o(err0)
   );

   dmem_responder #(
      .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .GNT_STALL(3), .RESP_LAT(4), .INTG_CHECK(1'b1)
   ) u1 (
      .CLK(clk), .RST_N(rst1), .data_req_i(req1), .data_gnt_o(gnt1), .data_rvalid_o(rvalid1),
      .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
      .data_wdata_intg_i(wintg), .data_rdata_o(rdata1), .data_rdata_intg_o(rintg1),
      .data_err_o(err1)
   );

   function automatic logic [6:0] intg(input logic [31:0] d);
      logic [6:0] r;
      r = '0;
      for (int i = 0; i < 7; i++)
         for (int j = i; j < 32; j += 7)
            r[i] = r[i] ^ d[j];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input logic [6:0] ig);
      we = w; be = b; addr = a; wdata = d; wintg = ig;
   endtask

   // Single isolated request on u0; entered and left at posedge+1.
   task automatic txn0(input string tag, input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input logic [6:0] ig,
                       input logic [31:0] exp_d, input logic exp_e);
      drive(w, b, a, d, ig);
      req0 = 1'b1;
      @(negedge clk);
      chk({tag, ".gnt"}, gnt0, 1);
      chk({tag, ".rv_early"}, rvalid0, 0);
      tick();
      req0 = 1'b0;
      @(negedge clk);
      chk({tag, ".rvalid"}, rvalid0, 1);
      chk({tag, ".rdata"}, rdata0, exp_d);
      chk({tag, ".rintg"}, rintg0, intg(exp_d));
      chk({tag, ".err"}, err0, exp_e);
      tick();
   endtask

   // Single isolated request on u1: grant in the 4th cycle, rvalid 4 cycles later.
   task automatic txn1(input string tag, input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input logic [6:0] ig,
                       input logic [31:0] exp_d, input logic exp_e);
      drive(w, b, a, d, ig);
      req1 = 1'b1;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         chk({tag, ".gnt"}, gnt1, (t == 3));
         if (t < 3) tick();
      end
      tick();
      req1 = 1'b0;
      for (int t = 4; t < 8; t++) begin
         @(negedge clk);
         chk({tag, ".rvalid"}, rvalid1, (t == 7));
         if (t < 7) tick();
      end
      chk({tag, ".rdata"}, rdata1, exp_d);
      chk({tag, ".err"}, err1, exp_e);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before the sequence completed");
      $fatal(1, "watchdog");
   end

   initial begin
      words[0] = 32'hA0A0_0001;
      words[1] = 32'hB0B0_0002;
      words[2] = 32'hC0C0_0003;

      rst0 = 1'b0; rst1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
      drive(1'b0, 4'h0, 32'h0, 32'h0, 7'h0);
      tick();
      tick();
      req0 = 1'b1;
      drive(1'b0, 4'hF, 32'h10, 32'h0, 7'h0);
      @(negedge clk);
      chk("rst.gnt_masked", gnt0, 0);
      chk("rst.rvalid0", rvalid0, 0);
      tick();
      rst0 = 1'b1; rst1 = 1'b1; req0 = 1'b0;
      @(negedge clk);
      chk("rel.gnt0", gnt0, 0);
      chk("rel.rvalid0", rvalid0, 0);
      chk("rel.rdata0", rdata0, 0);
      chk("rel.rintg0", rintg0, 0);
      chk("rel.err0", err0, 0);
      chk("rel.rvalid1", rvalid1, 0);
      tick();

      txn0("st10", 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, intg(32'hDEAD_BEEF), 32'h0, 1'b0);
      txn0("ld10", 1'b0, 4'h0, 32'h10, 32'h0, 7'h0, 32'hDEAD_BEEF, 1'b0);
      txn0("st20", 1'b1, 4'hF, 32'h20, 32'h1122_3344, intg(32'h1122_3344), 32'h0, 1'b0);
      txn0("st20be", 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, intg(32'hAABB_CCDD), 32'h0, 1'b0);
      txn0("ld20", 1'b0, 4'hF, 32'h20, 32'h0, 7'h0, 32'h11BB_33DD, 1'b0);
      txn0("ld_oob", 1'b0, 4'hF, 32'h1000, 32'h0, 7'h0, 32'h0, 1'b1);
      txn0("ld_top", 1'b0, 4'hF, 32'hFFC, 32'h0, 7'h0, 32'h0, 1'b0);
      txn0("ld_misal", 1'b0, 4'hF, 32'h12, 32'h0, 7'h0, 32'h0, 1'b1);
      txn0("st_badintg", 1'b1, 4'hF, 32'h10, 32'h1234_5678, intg(32'h1234_5678) ^ 7'h01, 32'h0, 1'b1);
      txn0("ld_after_bad", 1'b0, 4'hF, 32'h10, 32'h0, 7'h0, 32'hDEAD_BEEF, 1'b0);
      txn0("st_be0", 1'b1, 4'h0, 32'h10, 32'h0BAD_F00D, intg(32'h0BAD_F00D), 32'h0, 1'b0);
      txn0("ld_after_be0", 1'b0, 4'hF, 32'h10, 32'h0, 7'h0, 32'hDEAD_BEEF, 1'b0);

      // Store then load of the same word in consecutive grant cycles.
      drive(1'b1, 4'hF, 32'h40, 32'h0000_0005, intg(32'h0000_0005));
      req0 = 1'b1;
      @(negedge clk);
      chk("raw.st_gnt", gnt0, 1);
      tick();
      drive(1'b0, 4'hF, 32'h40, 32'h0, 7'h0);
      @(negedge clk);
      chk("raw.ld_gnt", gnt0, 1);
      chk("raw.st_rvalid", rvalid0, 1);
      chk("raw.st_rdata", rdata0, 0);
      tick();
      req0 = 1'b0;
      @(negedge clk);
      chk("raw.ld_rvalid", rvalid0, 1);
      chk("raw.ld_rdata", rdata0, 32'h5);
      chk("raw.ld_rintg", rintg0, intg(32'h5));
      tick();

      txn1("s1a", 1'b1, 4'hF, 32'h0, words[0], intg(words[0]), 32'h0, 1'b0);
      txn1("s1b", 1'b1, 4'hF, 32'h4, words[1], intg(words[1]), 32'h0, 1'b0);
      txn1("s1c", 1'b1, 4'hF, 32'h8, words[2], intg(words[2]), 32'h0, 1'b0);

      // Three back-to-back loads: grants at t=3,7,11, responses at t=7,11,15.
      req1 = 1'b1;
      for (int t = 0; t < 16; t++) begin
         logic exp_v;
         if (t < 12) drive(1'b0, 4'hF, 32'(4 * (t / 4)), 32'h0, 7'h0);
         else        req1 = 1'b0;
         exp_v = (t >= 7) && ((t - 7) % 4 == 0);
         @(negedge clk);
         chk("b2b.gnt", gnt1, (t < 12) && (t % 4 == 3));
         chk("b2b.rvalid", rvalid1, exp_v);
         chk("b2b.rdata", rdata1, exp_v ? words[(t - 7) / 4] : 32'h0);
         tick();
      end

      // Reset two cycles after a load grant discards the in-flight response.
      drive(1'b0, 4'hF, 32'h4, 32'h0, 7'h0);
      req1 = 1'b1;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         chk("mid.gnt", gnt1, (t == 3));
         if (t < 3) tick();
      end
      tick();
      req1 = 1'b0;
      @(negedge clk);
      tick();
      rst1 = 1'b0;
      req1 = 1'b1;
      drive(1'b1, 4'hF, 32'h0, 32'hFFFF_FFFF, intg(32'hFFFF_FFFF));
      for (int t = 5; t < 7; t++) begin
         @(negedge clk);
         chk("mid.rst_gnt", gnt1, 0);
         tick();
      end
      rst1 = 1'b1;
      req1 = 1'b0;
      @(negedge clk);
      chk("mid.rel_gnt", gnt1, 0);
      chk("mid.rel_rvalid", rvalid1, 0);
      chk("mid.rel_rdata", rdata1, 0);
      chk("mid.rel_rintg", rintg1, 0);
      chk("mid.rel_err", err1, 0);
      for (int t = 8; t < 14; t++) begin
         tick();
         @(negedge clk);
         chk("mid.no_rvalid", rvalid1, 0);
      end
      tick();
      txn1("ld_after_rst", 1'b0, 4'hF, 32'h0, 32'h0, 7'h0, words[0], 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
